// File: rtl/mov_fsm_param.sv
// Parametrised move-instruction FSM (MOVI / MOVIW / MOV) for the microcontroller
// control path. It decodes a move, optionally fetches an extension word, and
// drives register enables, the immediate bus and sequencer pulses.
// Outputs other than instr_ready are registered from next-state values, so each
// one lines up exactly with the state it belongs to.
module mov_fsm_param #(
  parameter int unsigned DW       = 16,
  parameter int unsigned NG       = 4,
  parameter int unsigned NP       = 2,
  parameter int unsigned SIGN_EXT = 0,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [3:0]  OP_MOVI  = 4'b0111,
  parameter logic [3:0]  OP_MOV   = 4'b0110,
  parameter logic [3:0]  OP_MOVIW = 4'b0101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              PC_inc,
  output logic              done,
  output logic              illegal,
  output logic              busy,
  output logic              immediate_out,
  output logic [DW-1:0]     bus_out,
  output logic [NG+NP-1:0]  src_out_en,
  output logic [NG+NP-1:0]  dst_in_en
);

  localparam int unsigned N  = NG + NP;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    FETCH_EXT = 3'd2,
    EXEC      = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [3:0]      op_q, op_n;
  logic [3:0]      dst_q, dst_n;
  logic [3:0]      src_q, src_n;
  logic [DW-1:0]   imm_q, imm_n;
  logic [CW-1:0]   cnt_q, cnt_n;

  logic            pc_n, done_n, ill_n, busy_n, immo_n;
  logic [DW-1:0]   bus_n;
  logic [N-1:0]    src_en_n, dst_en_n;

  function automatic logic idx_ok(input logic [3:0] idx);
    return 32'(idx) < N;
  endfunction

  function automatic logic is_move_op(input logic [3:0] op);
    return (op == OP_MOVI) || (op == OP_MOV) || (op == OP_MOVIW);
  endfunction

  function automatic logic [DW-1:0] ext8(input logic [7:0] b);
    if (SIGN_EXT != 0) return DW'($signed(b));
    else               return DW'(b);
  endfunction

  function automatic logic [DW-1:0] ext16(input logic [15:0] w);
    if (SIGN_EXT != 0) return DW'($signed(w));
    else               return DW'(w);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [3:0] idx);
    return N'(1) << idx;
  endfunction

  // Ready is a pure function of the current state
  always_comb begin
    instr_ready = (state == IDLE) || (state == FETCH_EXT);
  end

  // Next state, latched instruction fields, immediate and timeout counter
  always_comb begin
    state_n = state;
    op_n    = op_q;
    dst_n   = dst_q;
    src_n   = src_q;
    imm_n   = imm_q;
    cnt_n   = cnt_q;
    case (state)
      IDLE: begin
        if (instr_valid && is_move_op(instr[15:12])) begin
          op_n    = instr[15:12];
          dst_n   = instr[11:8];
          src_n   = instr[3:0];
          imm_n   = ext8(instr[7:0]);
          state_n = DECODE;
        end
      end
      DECODE: begin
        if (!idx_ok(dst_q) || (op_q == OP_MOV && !idx_ok(src_q))) begin
          state_n = ERROR;
        end else if (op_q == OP_MOV && src_q == dst_q) begin
          state_n = DONE;
        end else if (op_q == OP_MOVIW) begin
          cnt_n   = '0;
          state_n = FETCH_EXT;
        end else begin
          state_n = EXEC;
        end
      end
      FETCH_EXT: begin
        // a word arriving on the final wait cycle still beats the timeout
        if (instr_valid) begin
          imm_n   = ext16(instr);
          state_n = EXEC;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_n = ERROR;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      EXEC:    state_n = DONE;
      DONE:    state_n = IDLE;
      ERROR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output values for the state being entered, registered below
  always_comb begin
    pc_n     = 1'b0;
    done_n   = 1'b0;
    ill_n    = 1'b0;
    immo_n   = 1'b0;
    bus_n    = '0;
    src_en_n = '0;
    dst_en_n = '0;
    busy_n   = (state_n != IDLE);
    case (state_n)
      DECODE: pc_n = (op_n == OP_MOVIW) && idx_ok(dst_n);
      EXEC: begin
        dst_en_n = onehot(dst_n);
        if (op_n == OP_MOV) begin
          src_en_n = onehot(src_n);
        end else begin
          immo_n = 1'b1;
          bus_n  = imm_n;
        end
      end
      DONE: begin
        done_n = 1'b1;
        pc_n   = 1'b1;
      end
      ERROR: begin
        ill_n = 1'b1;
        pc_n  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, fields and output registers; reset aborts silently to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      op_q          <= '0;
      dst_q         <= '0;
      src_q         <= '0;
      imm_q         <= '0;
      cnt_q         <= '0;
      PC_inc        <= 1'b0;
      done          <= 1'b0;
      illegal       <= 1'b0;
      busy          <= 1'b0;
      immediate_out <= 1'b0;
      bus_out       <= '0;
      src_out_en    <= '0;
      dst_in_en     <= '0;
    end else begin
      state         <= state_n;
      op_q          <= op_n;
      dst_q         <= dst_n;
      src_q         <= src_n;
      imm_q         <= imm_n;
      cnt_q         <= cnt_n;
      PC_inc        <= pc_n;
      done          <= done_n;
      illegal       <= ill_n;
      busy          <= busy_n;
      immediate_out <= immo_n;
      bus_out       <= bus_n;
      src_out_en    <= src_en_n;
      dst_in_en     <= dst_en_n;
    end
  end

endmodule

// File: tb/tb_mov_fsm_param.sv
// Bench for mov_fsm_param: two instances (zero- and sign-extending) share the
// stimulus; an instruction-level model expands each move into its expected
// per-cycle output trace, checked every cycle, plus literal spot checks.
module tb_mov_fsm_param;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = 16'h7000;
  logic        instr_valid = 1'b0;

  logic        rdy_a, pc_a, done_a, ill_a, busy_a, immo_a;
  logic [15:0] bus_a;
  logic [5:0]  src_a, dst_a;
  logic        rdy_b, pc_b, done_b, ill_b, busy_b, immo_b;
  logic [15:0] bus_b;
  logic [5:0]  src_b, dst_b;

  mov_fsm_param #(.DW(16), .NG(4), .NP(2), .SIGN_EXT(0), .TIMEOUT(TO)) u_dut_z (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(rdy_a), .PC_inc(pc_a), .done(done_a), .illegal(ill_a),
    .busy(busy_a), .immediate_out(immo_a), .bus_out(bus_a),
    .src_out_en(src_a), .dst_in_en(dst_a)
  );

  mov_fsm_param #(.DW(16), .NG(4), .NP(2), .SIGN_EXT(1), .TIMEOUT(TO)) u_dut_s (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(rdy_b), .PC_inc(pc_b), .done(done_b), .illegal(ill_b),
    .busy(busy_b), .immediate_out(immo_b), .bus_out(bus_b),
    .src_out_en(src_b), .dst_in_en(dst_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready, pc, done, ill, busy, imm;
    logic [15:0] bz, bs;
    logic [5:0]  src, dst;
  } rec_t;

  rec_t expq [0:1023];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t idle_rec();
    rec_t r;
    r = '0;
    r.ready = 1'b1;
    return r;
  endfunction

  function automatic rec_t busy_rec();
    rec_t r;
    r = '0;
    r.busy = 1'b1;
    return r;
  endfunction

  // Expand one accepted word (issued in cycle c) into its expected trace.
  // gap = FETCH_EXT cycles without a word before ext arrives; gap >= TO means none.
  task automatic model(input int c, input logic [15:0] w, input int gap, input logic [15:0] ext);
    int t;
    logic [3:0] op, d, s;
    logic badi;
    logic [15:0] bz, bs;
    rec_t r;
    int nwait;
    t  = c + 1;
    op = w[15:12];
    d  = w[11:8];
    s  = w[3:0];
    if (op != 4'h7 && op != 4'h6 && op != 4'h5) return;
    badi = (d >= 4'd6) || (op == 4'h6 && s >= 4'd6);
    r = busy_rec();
    if (op == 4'h5 && !badi) r.pc = 1'b1;
    expq[t] = r; t++;
    if (badi) begin
      r = busy_rec(); r.ill = 1'b1; r.pc = 1'b1; expq[t] = r;
      return;
    end
    if (op == 4'h6 && s == d) begin
      r = busy_rec(); r.done = 1'b1; r.pc = 1'b1; expq[t] = r;
      return;
    end
    bz = 16'h0; bs = 16'h0;
    if (op == 4'h7) begin
      bz = {8'h00, w[7:0]};
      bs = {{8{w[7]}}, w[7:0]};
    end else if (op == 4'h5) begin
      bz = ext; bs = ext;
      nwait = (gap < TO) ? gap + 1 : TO;
      for (int i = 0; i < nwait; i++) begin
        r = busy_rec(); r.ready = 1'b1; expq[t] = r; t++;
      end
      if (gap >= TO) begin
        r = busy_rec(); r.ill = 1'b1; r.pc = 1'b1; expq[t] = r;
        return;
      end
    end
    r = busy_rec();
    r.dst = 6'd1 << d;
    if (op == 4'h6) r.src = 6'd1 << s;
    else begin
      r.imm = 1'b1; r.bz = bz; r.bs = bs;
    end
    expq[t] = r; t++;
    r = busy_rec(); r.done = 1'b1; r.pc = 1'b1; expq[t] = r;
  endtask

  logic [33:0] act_a, act_b, want_a, want_b;
  rec_t cur;

  // Per-cycle trace comparison for both instances
  always @(negedge clk) begin
    if (cyc < 1024) begin
      cur    = expq[cyc];
      act_a  = {rdy_a, pc_a, done_a, ill_a, busy_a, immo_a, bus_a, src_a, dst_a};
      act_b  = {rdy_b, pc_b, done_b, ill_b, busy_b, immo_b, bus_b, src_b, dst_b};
      want_a = {cur.ready, cur.pc, cur.done, cur.ill, cur.busy, cur.imm, cur.bz, cur.src, cur.dst};
      want_b = {cur.ready, cur.pc, cur.done, cur.ill, cur.busy, cur.imm, cur.bs, cur.src, cur.dst};
      total++;
      if (act_a !== want_a) begin
        bad++;
        $display("FAIL trace_zext cyc=%0d got=%h want=%h", cyc, act_a, want_a);
      end
      total++;
      if (act_b !== want_b) begin
        bad++;
        $display("FAIL trace_sext cyc=%0d got=%h want=%h", cyc, act_b, want_b);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input int gap, input logic [15:0] ext);
    model(cyc, w, gap, ext);
    instr = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr = 16'h7000;
  endtask

  task automatic ext_word(input logic [15:0] x);
    instr = x;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr = 16'h7000;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) expq[i] = idle_rec();

    // reset state
    step(); step();
    chk("rst_ready", 32'(rdy_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_dst", 32'(dst_a), 32'd0);
    step();
    rst = 1'b1;
    step(); step();

    // MOVI G0 #2
    send(16'h7002, TO, 16'h0);
    step();
    chk("movi_g0_dst", 32'(dst_a), 32'h01);
    chk("movi_g0_imm", 32'(immo_a), 32'd1);
    chk("movi_g0_bus", 32'(bus_a), 32'h0002);
    step();
    chk("movi_g0_done", 32'({done_a, pc_a}), 32'b11);
    step();
    chk("movi_g0_idle", 32'({busy_a, rdy_a}), 32'b01);
    step();

    // MOVI P1 #FE, both extension modes
    send(16'h75FE, TO, 16'h0);
    step();
    chk("movi_p1_dst", 32'(dst_b), 32'h20);
    chk("movi_p1_bus_z", 32'(bus_a), 32'h00FE);
    chk("movi_p1_bus_s", 32'(bus_b), 32'hFFFE);
    repeat (3) step();

    // MOVIW G2, extension after three idle cycles
    send(16'h5200, 2, 16'hBEEF);
    chk("moviw_dec_pc", 32'({pc_a, rdy_a}), 32'b10);
    step();
    chk("moviw_fetch_ready", 32'(rdy_a), 32'd1);
    step(); step();
    ext_word(16'hBEEF);
    chk("moviw_bus", 32'(bus_b), 32'hBEEF);
    chk("moviw_dst", 32'(dst_a), 32'h04);
    step();
    chk("moviw_done", 32'({done_a, pc_a}), 32'b11);
    repeat (2) step();

    // MOV G3 <- P0 with a stray word while not ready
    send(16'h6304, TO, 16'h0);
    step();
    chk("mov_src", 32'(src_a), 32'h10);
    chk("mov_dst", 32'(dst_a), 32'h08);
    chk("mov_imm", 32'(immo_a), 32'd0);
    instr = 16'h7001;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr = 16'h7000;
    step();
    chk("stray_ignored", 32'(busy_a), 32'd0);
    step();

    // MOV G1 <- G1 no-op
    send(16'h6101, TO, 16'h0);
    step();
    chk("mov_same_done", 32'({done_a, src_a, dst_a}), 32'h1000);
    step(); step();

    // unrelated opcode is ignored
    send(16'h1234, TO, 16'h0);
    chk("ignored_op", 32'(busy_a), 32'd0);
    step();

    // MOVI bad destination
    send(16'h7F00, TO, 16'h0);
    step();
    chk("movi_bad_dst", 32'({ill_a, pc_a, dst_a}), 32'h0C0);
    step(); step();

    // MOV bad source, MOVIW bad destination
    send(16'h6007, TO, 16'h0);
    repeat (3) step();
    send(16'h5900, TO, 16'h0);
    repeat (3) step();

    // MOVIW extension on the last allowed wait cycle
    send(16'h5100, TO - 1, 16'h8001);
    repeat (TO) step();
    ext_word(16'h8001);
    chk("moviw_late_bus", 32'(bus_a), 32'h8001);
    repeat (3) step();

    // MOVIW timeout
    send(16'h5300, TO, 16'h0);
    repeat (TO + 1) step();
    chk("moviw_timeout", 32'({ill_a, pc_a}), 32'b11);
    repeat (3) step();

    // reset during FETCH_EXT aborts silently
    send(16'h5300, TO, 16'h0);
    step(); step();
    for (int i = 0; i < 40; i++) expq[cyc + i] = idle_rec();
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'({busy_a, pc_a, ill_a, done_a, rdy_a}), 32'b00001);
    step();
    rst = 1'b1;
    repeat (TO + 2) step();

    // still functional after the abort
    send(16'h7281, TO, 16'h0);
    step();
    chk("post_rst_bus_s", 32'(bus_b), 32'hFF81);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mov_fsm_param.md
Name: mov_fsm_param

Overview:
- Parametrised successor to the single-form move-immediate FSM in the microcontroller control path.
- Executes three move instructions:
  - MOVI: 8-bit immediate.
  - MOVIW: immediate carried in the next instruction word.
  - MOV: register to register.
- Targets a configurable register file of NG general (G) and NP pointer (P) registers.
- Drives register load enables, source output enables, the immediate bus, and the PC_inc, done and illegal pulses toward the sequencer.

Parameters:
- DW, 16, data/immediate bus width (must be >= 16).
- NG, 4, number of general registers G0..G(NG-1).
- NP, 2, number of pointer registers P0..P(NP-1).
- SIGN_EXT, 0, 1 = sign-extend immediates to DW; 0 = zero-extend.
- TIMEOUT, 15, maximum cycles to wait for the MOVIW extension word (>= 1).
- OP_MOVI, 4'b0111, opcode of MOVI.
- OP_MOV, 4'b0110, opcode of MOV.
- OP_MOVIW, 4'b0101, opcode of MOVIW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr  in  16  instruction/extension word; [15:12] opcode, [11:8] dst index, [7:0] imm8 (MOVI), [3:0] src index (MOV).
- instr_valid  in  1  instr holds a valid word this cycle.
- instr_ready  out  1  FSM can accept a word (combinational from state).
- PC_inc  out  1  one-cycle program-counter increment pulse.
- done  out  1  one-cycle pulse: move completed.
- illegal  out  1  one-cycle pulse: bad index or extension timeout.
- busy  out  1  state != IDLE.
- immediate_out  out  1  bus_out carries an immediate this cycle.
- bus_out  out  DW  immediate value; 0 when immediate_out=0.
- src_out_en  out  NG+NP  one-hot source register drive enable.
- dst_in_en  out  NG+NP  one-hot destination load enable.

Index map: 0..NG-1 = G0..G(NG-1); NG..NG+NP-1 = P0..P(NP-1); >= NG+NP is illegal.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs, the timeout counter and latched fields clear to 0.
  - instr_ready=1 (IDLE decode).
  - Reset mid-operation aborts with no done or illegal pulse.
- States: IDLE, DECODE, FETCH_EXT, EXEC, DONE, ERROR.
- IDLE:
  - instr_ready=1.
  - instr_valid with opcode in {MOVI, MOV, MOVIW}: latch instr, go to DECODE.
  - Any other opcode is ignored; stay in IDLE with no pulses.
- DECODE (1 cycle):
  - dst >= NG+NP, or MOV with src >= NG+NP: go to ERROR.
  - MOV with src == dst: go to DONE (no-op, no enables).
  - MOVIW: PC_inc=1, clear the counter, go to FETCH_EXT.
  - Otherwise: go to EXEC.
- FETCH_EXT:
  - instr_ready=1; the counter increments each cycle.
  - instr_valid: latch instr[15:0] as the immediate (extended to DW per SIGN_EXT), go to EXEC.
  - Counter reaching TIMEOUT without instr_valid: go to ERROR.
  - instr_valid in the same cycle as the timeout: accept the word (valid wins).
- EXEC (1 cycle):
  - MOVI/MOVIW: immediate_out=1, bus_out = extended immediate, dst_in_en[dst]=1.
  - MOV: src_out_en[src]=1, dst_in_en[dst]=1, immediate_out=0.
- DONE (1 cycle): done=1, PC_inc=1, then go to IDLE.
- ERROR (1 cycle): illegal=1, PC_inc=1, no enables, then go to IDLE.
- All enables and pulses are asserted only in their named states and are exactly one cycle wide.
- At most one bit of src_out_en and one bit of dst_in_en is set at any time.
- Latency (acceptance edge = k):
  - MOVI/MOV: DECODE in cycle k+1, EXEC in k+2, DONE in k+3; back in IDLE and ready at k+4.
  - MOVIW adds one cycle per FETCH_EXT wait cycle.
- Words presented while instr_ready=0 are neither latched nor consumed.

Test Plan:
- MOVI G0: instr=16'b0111_0000_0000_0010 for one cycle after reset.
  - Required: dst_in_en=6'b000001, immediate_out=1, bus_out=16'h0002 two cycles after acceptance.
  - Then done=1 and PC_inc=1 for one cycle; busy clears.
- SIGN_EXT=1, MOVI P1: instr=16'h75FE.
  - Required: dst_in_en=6'b100000, bus_out=16'hFFFE.
  - With SIGN_EXT=0: bus_out=16'h00FE.
- MOVIW G2: instr=16'h5200, then 3 idle cycles, then instr=16'hBEEF.
  - Required: PC_inc pulse from DECODE, bus_out=16'hBEEF, dst_in_en=6'b000100, then done plus a second PC_inc.
- MOV G3 <- P0 (instr=16'h6304): required src_out_en=6'b010000, dst_in_en=6'b001000, immediate_out=0.
- MOV G1 <- G1 (instr=16'h6101): required done after 2 cycles with no enables.
- Error paths:
  - MOVI dst 4'hF (16'h7F00): illegal=1 and PC_inc=1, no dst_in_en.
  - MOVIW with no extension word for TIMEOUT cycles: illegal=1.
  - rst pulled low during FETCH_EXT: immediate return to IDLE, no done or illegal pulse.
